multi_tick_gen: RTL

- Parametrised successor to the single 1 Hz divider. Generates NUM_CH independent divided clocks with 50% duty, each with a matching single-cycle tick strobe.
- Every channel has a runtime-programmable half-period, reloaded glitch-free at the channel's wrap.
- Feeds the clock's seconds counter, the blink logic and the display-refresh scanner from one block.

---
 rtl/multi_tick_gen.sv | 62 ++++++
 1 files changed

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NUM_CH 50%-duty clock dividers with tick strobes, runtime half-periods reloaded at wrap (ports: clk rst_n en clr div_wr div_sel div_val -> div_err pend clk_out tick)
module multi_tick_gen #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 27,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = {27'd50000, 27'd25000000, 27'd50000000}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              div_wr,
  input  logic [2:0]        div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic              div_err,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  logic acc, rej;
  assign acc = div_wr && div_val != '0 && int'(div_sel) < NUM_CH;
  assign rej = div_wr && !acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_err <= 1'b0;
    else div_err <= rej;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt, half, shadow;
    logic pnd, co, tk, hit, wrap;
    assign hit = acc && int'(div_sel) == i;
    // >= rather than == keeps the period bounded if an idle reload shrinks half below cnt
    assign wrap = cnt >= half - CNT_W'(1);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        half <= DEF_HALF[i*CNT_W +: CNT_W];
        shadow <= '0;
        pnd <= 1'b0;
        co <= 1'b0;
        tk <= 1'b0;
      end else begin
        if (clr) begin
          cnt <= '0;
          co <= 1'b0;
          tk <= 1'b0;
        end else if (en) begin
          cnt <= wrap ? '0 : cnt + CNT_W'(1);
          co <= co ^ wrap;
          tk <= wrap && !co;
        end else tk <= 1'b0;
        if (pnd && (clr || !en || wrap)) begin
          half <= shadow;
          pnd <= 1'b0;
        end
        if (hit) begin
          shadow <= div_val;
          pnd <= 1'b1;
        end
      end
    assign pend[i] = pnd;
    assign clk_out[i] = co;
    assign tick[i] = tk;
  end
endmodule
